sha256_mem_responder: RTL and testbench
=======================================

// Module: sha256_mem_responder
// PURPOSE
// Memory-side responder and host front end for simplified_sha256. It owns a
// word-addressed RAM and serves the core's mem_addr/mem_we/mem_write_data bus
// with registered one-cycle read data. It loads a host-streamed message, kicks
// the core, then streams the 8-word digest back to the host.
// PARAMETERS
// MEM_DEPTH  64     RAM depth in 32-bit words; valid addresses are 0..MEM_DEPTH-1
// MSG_BASE   0      word address of message word 0; drives message_addr
// OUT_BASE   32     word address of digest word 0; drives output_addr
// MSG_WORDS  20     message words accepted per job (640-bit header)
// TIMEOUT    1023   RUN-state cycle limit before the job is aborted
// PORTS
// clk             in   1   clock; also the core's mem_clk domain
// reset           in   1   asynchronous active-high reset
// in_valid        in   1   host message word valid
// in_data         in   32  host message word
// in_ready        out  1   block accepts in_data this cycle
// out_valid       out  1   digest word valid
// out_data        out  32  digest word, H0 first
// out_last        out  1   high with the 8th digest word
// out_ready       in   1   host accepts out_data
// busy            out  1   high in any state other than IDLE
// err             out  1   sticky: core address out of range, or timeout; cleared at next job start
// core_rst_n      out  1   active-low reset to the core
// start           out  1   one-cycle start pulse to the core
// done            in   1   core done (held high until core reset)
// message_addr    out  16  constant MSG_BASE
// output_addr     out  16  constant OUT_BASE
// mem_addr        in   16  core word address
// mem_we          in   1   core write enable
// mem_write_data  in   32  core write data
// mem_read_data   out  32  registered RAM read data
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0,
//   err=0, start=0, core_rst_n=0, mem_read_data=0. RAM contents are not reset.
// - Every cycle: mem_read_data <= (mem_addr<MEM_DEPTH) ? ram[mem_addr] : 0, with
//   read-before-write on the same address. Latency is exactly one clk.
// - Core writes are committed only in RUN with mem_we=1 and an in-range address.
//   Any out-of-range core access (mem_we or not) in RUN sets err; the write is dropped.
// - FSM states and transitions:
//   IDLE : in_ready=1, core_rst_n=0. The first accepted word goes to
//          ram[MSG_BASE], clears err, sets the load counter to 1 and enters LOAD
//          (or START if MSG_WORDS==1).
//   LOAD : in_ready=1; in_valid writes ram[MSG_BASE+cnt] and increments cnt.
//          After word MSG_WORDS-1 is accepted: in_ready=0 and go to START.
//   START: core_rst_n=1 this cycle. The next cycle is RUN entry.
//   RUN  : start=1 on the first RUN cycle only. The watchdog counts up from 0.
//          If done=1, go to DRAIN. If the watchdog reaches TIMEOUT, set err and go
//          to IDLE; digest is not streamed.
//   DRAIN: for i=0..7: issue an internal read of OUT_BASE+i; one cycle later
//          out_data=word and out_valid=1, held stable until out_ready. On
//          acceptance, clear out_valid and issue read i+1. out_last=1 when i==7.
//          After word 7 is accepted, go to IDLE with core_rst_n=0.
//          Throughput is one word per 2 cycles plus backpressure stall cycles.
// - DRAIN reads use the internal port. mem_read_data still tracks mem_addr.
// - in_valid outside IDLE/LOAD is ignored (in_ready=0). out_ready outside DRAIN
//   is ignored.
// - LOAD/DRAIN counters and the watchdog reset to 0 on every entry to IDLE.
// - Reset asserted mid-job: return to IDLE immediately and drop any partial
//   load or drain. core_rst_n=0 holds the core in reset.
// - MSG_BASE+MSG_WORDS and OUT_BASE+8 must both be <= MEM_DEPTH, and the two
//   regions must not overlap. Violations are elaboration errors.
// TESTING
// 1 Reset mid-LOAD after 5 words -> IDLE; in_ready=1; next job reloads from
//   ram[MSG_BASE]; err=0.
// 2 Core-side read mem_addr=3 with ram[3]=0xDEADBEEF -> mem_read_data=0xDEADBEEF
//   exactly one clk later. Read mem_addr=0x0100 -> 0 and err=1.
// 3 20-word Bitcoin header streamed at full rate with the real core attached ->
//   start pulses once; 8 out words match the golden SHA-256 model; out_last on word 8.
// 4 Drain with out_ready low for 10 cycles on word 2 -> out_data and out_valid
//   stable throughout; no word lost or duplicated.
// 5 Stub core that never asserts done -> err=1 after 1023 RUN cycles; out_valid
//   never asserted; returns to IDLE.
// 6 Core writes 0x12345678 to OUT_BASE+0 while mem_addr reads the same address
//   that cycle -> old data returned; new data returned the next cycle.

Source files
------------

// File: rtl/sha256_mem_responder.sv
// Memory-side responder and host front end for simplified_sha256: owns the word RAM,
// loads a streamed message, runs the core under a watchdog, then streams the digest.
module sha256_mem_responder #(
  parameter int MEM_DEPTH = 64,
  parameter int MSG_BASE  = 0,
  parameter int OUT_BASE  = 32,
  parameter int MSG_WORDS = 20,
  parameter int TIMEOUT   = 1023
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  input  logic [31:0] i_in_data,
  output logic        o_in_ready,
  output logic        o_out_valid,
  output logic [31:0] o_out_data,
  output logic        o_out_last,
  input  logic        i_out_ready,
  output logic        o_busy,
  output logic        o_err,
  output logic        o_core_rst_n,
  output logic        o_start,
  input  logic        i_done,
  output logic [15:0] o_message_addr,
  output logic [15:0] o_output_addr,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_write_data,
  output logic [31:0] o_mem_read_data
);

  // state | meaning
  // IDLE  | waiting for first message word, core held in reset
  // LOAD  | accepting remaining message words
  // START | core released from reset
  // RUN   | core active, start pulse then watchdog
  // DRAIN | streaming 8 digest words to host
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN} state_t;

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(MSG_WORDS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] MSG_IDX  = AW'(MSG_BASE);
  localparam logic [AW-1:0] OUT_IDX  = AW'(OUT_BASE);
  localparam logic [CW-1:0] LAST_CNT = CW'(MSG_WORDS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  if (MSG_BASE + MSG_WORDS > MEM_DEPTH) begin : g_bad_msg
    $error("message region exceeds MEM_DEPTH");
  end
  if (OUT_BASE + 8 > MEM_DEPTH) begin : g_bad_out
    $error("digest region exceeds MEM_DEPTH");
  end
  if (!((MSG_BASE + MSG_WORDS <= OUT_BASE) || (OUT_BASE + 8 <= MSG_BASE))) begin : g_overlap
    $error("message and digest regions overlap");
  end

  logic [31:0]   r_ram [MEM_DEPTH];
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_wdog;
  logic [2:0]    r_didx;
  logic          r_issue;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [31:0]   r_out_data;
  logic          r_out_last;
  logic          r_busy;
  logic          r_err;
  logic          r_core_rst_n;
  logic          r_start;
  logic [31:0]   r_mem_read_data;

  logic          w_core_in_range;
  logic [AW-1:0] w_core_idx;
  logic [AW-1:0] w_drain_idx;
  logic          w_host_acc;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;

  assign w_core_in_range = ({16'b0, i_mem_addr} < 32'(MEM_DEPTH));
  assign w_core_idx      = i_mem_addr[AW-1:0];
  assign w_drain_idx     = OUT_IDX + AW'(r_didx);
  assign w_host_acc      = r_in_ready && i_in_valid;

  // Single RAM write port: host loads in IDLE/LOAD, core writes only in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = MSG_IDX + AW'(r_cnt);
    w_wdata = i_in_data;
    if ((r_state == S_IDLE || r_state == S_LOAD) && w_host_acc) begin
      w_we = 1'b1;
    end else if (r_state == S_RUN && i_mem_we && w_core_in_range) begin
      w_we    = 1'b1;
      w_waddr = w_core_idx;
      w_wdata = i_mem_write_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_ram[w_waddr] <= w_wdata;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_mem_read_data <= '0;
    else         r_mem_read_data <= w_core_in_range ? r_ram[w_core_idx] : '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wdog       <= '0;
      r_didx       <= '0;
      r_issue      <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_start      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready   <= 1'b1;
          r_core_rst_n <= 1'b0;
          r_busy       <= 1'b0;
          r_cnt        <= '0;
          r_wdog       <= '0;
          r_didx       <= '0;
          if (w_host_acc) begin
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            if (MSG_WORDS == 1) begin
              r_in_ready   <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_state      <= S_START;
            end else begin
              r_cnt   <= CW'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_host_acc) begin
            if (r_cnt == LAST_CNT) begin
              r_in_ready   <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_cnt        <= '0;
              r_state      <= S_START;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_START: begin
          r_start <= 1'b1;
          r_wdog  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (!w_core_in_range) r_err <= 1'b1;
          if (i_done) begin
            r_didx  <= '0;
            r_issue <= 1'b1;
            r_wdog  <= '0;
            r_state <= S_DRAIN;
          end else if (r_wdog == WD_LAST) begin
            r_err        <= 1'b1;
            r_wdog       <= '0;
            r_busy       <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_in_ready   <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
        end
        S_DRAIN: begin
          // Issue cycle reads the RAM; the word is presented one cycle later.
          if (r_issue) begin
            r_out_data  <= r_ram[w_drain_idx];
            r_out_valid <= 1'b1;
            r_out_last  <= (r_didx == 3'd7);
            r_issue     <= 1'b0;
          end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_didx == 3'd7) begin
              r_didx       <= '0;
              r_busy       <= 1'b0;
              r_core_rst_n <= 1'b0;
              r_in_ready   <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_didx  <= r_didx + 3'd1;
              r_issue <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_out_valid     = r_out_valid;
  assign o_out_data      = r_out_data;
  assign o_out_last      = r_out_last;
  assign o_busy          = r_busy;
  assign o_err           = r_err;
  assign o_core_rst_n    = r_core_rst_n;
  assign o_start         = r_start;
  assign o_message_addr  = 16'(MSG_BASE);
  assign o_output_addr   = 16'(OUT_BASE);
  assign o_mem_read_data = r_mem_read_data;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed bench for sha256_mem_responder; the bench itself plays the core on the
// memory bus and supplies the digest words the responder must stream back.
module tb_sha256_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        err;
  logic        core_rst_n;
  logic        start;
  logic        done;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_vec   = 0;
  int n_miss  = 0;
  int n_start = 0;

  // SHA-256("abc"), H0 first
  logic [31:0] dig [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  sha256_mem_responder dut (
    .i_clk(clk), .i_reset(reset),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_last(out_last),
    .i_out_ready(out_ready),
    .o_busy(busy), .o_err(err), .o_core_rst_n(core_rst_n), .o_start(start),
    .i_done(done),
    .o_message_addr(message_addr), .o_output_addr(output_addr),
    .i_mem_addr(mem_addr), .i_mem_we(mem_we), .i_mem_write_data(mem_write_data),
    .o_mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start) n_start++;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200us");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] msg(input int i);
    return 32'hA5A50000 + 32'(i);
  endfunction

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      chk("load_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic core_cycle(input logic [15:0] a, input logic we, input logic [31:0] d);
    mem_addr       = a;
    mem_we         = we;
    mem_write_data = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic drain(input int stall_idx, input int stall_n);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 6 && !out_valid; k++) tick();
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, dig[i]);
      chk("drain_last", out_last, 32'(i == 7));
      if (i == stall_idx) begin
        for (int k = 0; k < stall_n; k++) begin
          tick();
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, dig[i]);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("accept_clear", out_valid, 0);
    end
  endtask

  initial begin
    int n;
    logic ov_seen;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done = 1'b0;
    mem_addr = '0; mem_we = 1'b0; mem_write_data = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", start, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_rd_data", mem_read_data, 0);
    chk("message_addr", 32'(message_addr), 0);
    chk("output_addr", 32'(output_addr), 32);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // reset in the middle of a load
    load(5, 32'h11110000);
    chk("partial_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_err", err, 0);

    // job 1: full load, bench acts as the core
    load(20, msg(0));
    chk("start_core_rst_n", core_rst_n, 1);
    chk("start_in_ready", in_ready, 0);
    chk("start_busy", busy, 1);
    tick();
    chk("run_start", start, 1);
    core_cycle(16'd0, 1'b0, '0);
    chk("rd_msg0", mem_read_data, msg(0));
    core_cycle(16'd4, 1'b0, '0);
    chk("rd_msg4", mem_read_data, msg(4));
    core_cycle(16'd19, 1'b0, '0);
    chk("rd_msg19", mem_read_data, msg(19));
    chk("run_start_gone", start, 0);

    core_cycle(16'd3, 1'b1, 32'hDEADBEEF);
    chk("wr3_old", mem_read_data, msg(3));
    mem_addr = 16'd3;
    #1;
    chk("rd3_not_early", mem_read_data, msg(3));
    core_cycle(16'd3, 1'b0, '0);
    chk("rd3_new", mem_read_data, 32'hDEADBEEF);

    core_cycle(16'd32, 1'b1, 32'h0BADF00D);
    core_cycle(16'd32, 1'b1, 32'h12345678);
    chk("rbw_old", mem_read_data, 32'h0BADF00D);
    core_cycle(16'd32, 1'b0, '0);
    chk("rbw_new", mem_read_data, 32'h12345678);

    for (int i = 0; i < 8; i++) core_cycle(16'(32 + i), 1'b1, dig[i]);
    core_cycle(16'd38, 1'b0, '0);
    chk("rd_dig6", mem_read_data, dig[6]);
    chk("err_before_oor", err, 0);
    core_cycle(16'h0100, 1'b0, '0);
    chk("oor_rd_data", mem_read_data, 0);
    chk("oor_err", err, 1);
    core_cycle(16'h0100, 1'b1, 32'hFFFFFFFF);
    mem_addr = 16'd32;
    tick();
    chk("oor_wr_dropped", mem_read_data, dig[0]);

    done = 1'b1;
    tick();
    chk("drain_busy", busy, 1);
    drain(2, 10);
    done = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_core_rst_n", core_rst_n, 0);
    chk("end_in_ready", in_ready, 1);
    chk("end_err_sticky", err, 1);
    tick();
    chk("no_extra_word", out_valid, 0);
    chk("start_count1", 32'(n_start), 1);

    // job 2: core never finishes
    mem_addr = 16'd0;
    load(20, msg(100));
    chk("job2_err_cleared", err, 0);
    tick();
    chk("job2_start", start, 1);
    n = 0;
    ov_seen = 1'b0;
    while (busy && n < 1100) begin
      if (out_valid) ov_seen = 1'b1;
      n++;
      tick();
    end
    chk("timeout_cycles", 32'(n), 1023);
    chk("timeout_err", err, 1);
    chk("timeout_no_out", ov_seen, 0);
    chk("timeout_in_ready", in_ready, 1);
    chk("timeout_core_rst", core_rst_n, 0);
    tick();
    chk("timeout_out_valid", out_valid, 0);
    chk("start_count2", 32'(n_start), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
